// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types for the LSU memory arbiter: FSM state encoding and a small index helper.
package lsu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    READ_WAITING  = 2'd1,
    WRITE_WAITING = 2'd2,
    RELAYING      = 2'd3
  } mem_arb_state_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/lsu_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  int idx;

  // Scan from the farthest offset down so the closest requester to ptr is assigned last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one data-memory channel between per-thread LSUs, one transaction at a time,
// with round-robin grant and a ready hold-until-valid-drops handshake back to the LSU.
//
// state         | meaning
// IDLE          | no transaction; grant the next requester at/after rr_ptr
// READ_WAITING  | mem read request outstanding for granted LSU
// WRITE_WAITING | mem write request outstanding for granted LSU
// RELAYING      | ready asserted to granted LSU until it drops its valid
module lsu_mem_arbiter
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  mem_arb_state_t state, state_next;

  logic [IDX_W-1:0]         grant;
  logic [IDX_W-1:0]         rr_ptr;
  logic                     op_read;
  logic [NUM_CONSUMERS-1:0] req;
  logic                     arb_valid;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_is_read;
  logic                     held_valid;

  assign req         = consumer_read_valid | consumer_write_valid;
  assign arb_is_read = consumer_read_valid[arb_idx];
  assign held_valid  = op_read ? consumer_read_valid[grant] : consumer_write_valid[grant];

  rr_arbiter #(
    .N     (NUM_CONSUMERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req         (req),
    .ptr         (rr_ptr),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:          if (arb_valid) state_next = arb_is_read ? READ_WAITING : WRITE_WAITING;
      READ_WAITING:  if (mem_read_ready) state_next = RELAYING;
      WRITE_WAITING: if (mem_write_ready) state_next = RELAYING;
      RELAYING:      if (!held_valid) state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  // Datapath: everything the FSM drives is registered so it only moves on transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant                <= '0;
      rr_ptr               <= '0;
      op_read              <= 1'b0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant   <= arb_idx;
            op_read <= arb_is_read;
            if (arb_is_read) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[int'(arb_idx)*ADDR_BITS +: ADDR_BITS];
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[int'(arb_idx)*ADDR_BITS +: ADDR_BITS];
              mem_write_data    <= consumer_write_data[int'(arb_idx)*DATA_BITS +: DATA_BITS];
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready) begin
            mem_read_valid                                          <= 1'b0;
            consumer_read_data[int'(grant)*DATA_BITS +: DATA_BITS] <= mem_read_data;
            consumer_read_ready[grant]                              <= 1'b1;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready) begin
            mem_write_valid             <= 1'b0;
            consumer_write_ready[grant] <= 1'b1;
          end
        end
        RELAYING: begin
          if (!held_valid) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            rr_ptr               <= IDX_W'(wrap_inc(int'(grant), NUM_CONSUMERS));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: transaction-level reference model checked every cycle,
// directed LSU scenarios, and literal checks on grant order and returned data.
module tb_lsu_mem_arbiter;

  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   rv = '0, wv = '0;
  logic [N*A-1:0] raddr = '0, waddr = '0;
  logic [N*D-1:0] wdata = '0;
  logic [N-1:0]   consumer_read_ready, consumer_write_ready;
  logic [N*D-1:0] consumer_read_data;
  logic           mem_read_valid, mem_write_valid;
  logic [A-1:0]   mem_read_address, mem_write_address;
  logic [D-1:0]   mem_write_data;
  logic           mem_read_ready = 1'b0, mem_write_ready = 1'b0;
  logic [D-1:0]   mem_read_data = '0;

  int vectors = 0;
  int miscompares = 0;

  lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rv),
    .consumer_read_address  (raddr),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (wv),
    .consumer_write_address (waddr),
    .consumer_write_data    (wdata),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [D-1:0] mem [256];
  logic [A-1:0] rlog[$];
  logic [A-1:0] wlog_a[$];
  logic [D-1:0] wlog_d[$];
  int           lat = 0;
  logic         prev_rv = 1'b0;

  initial forever begin
    @(negedge clk);
    if (mem_read_valid && !reset) begin
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (reset) break;
      end
      if (!reset && mem_read_valid) begin
        mem_read_data  = mem[mem_read_address];
        mem_read_ready = 1'b1;
        @(negedge clk);
        mem_read_ready = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mem_write_valid && !reset) begin
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (reset) break;
      end
      if (!reset && mem_write_valid) begin
        mem[mem_write_address] = mem_write_data;
        wlog_a.push_back(mem_write_address);
        wlog_d.push_back(mem_write_data);
        mem_write_ready = 1'b1;
        @(negedge clk);
        mem_write_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_read_valid && !prev_rv) rlog.push_back(mem_read_address);
    prev_rv = mem_read_valid;
  end

  // ---------------- reference model ----------------
  // One outstanding transaction; after completion the LSU is told "ready" until it lets go,
  // then the pointer moves past it and at least one quiet cycle follows.
  int             m_ptr, m_g, mk;
  bit             m_rd, m_busy_mem, m_busy_relay;
  logic [N-1:0]   e_rr, e_wr;
  logic [N*D-1:0] e_rdata;
  logic           e_rv, e_wv;
  logic [A-1:0]   e_ra, e_wa;
  logic [D-1:0]   e_wd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ptr = 0; m_g = 0; m_rd = 0; m_busy_mem = 0; m_busy_relay = 0;
      e_rr = '0; e_wr = '0; e_rdata = '0; e_rv = 0; e_wv = 0;
      e_ra = '0; e_wa = '0; e_wd = '0;
    end else if (m_busy_mem) begin
      if (m_rd && mem_read_ready) begin
        e_rv = 0;
        e_rdata[m_g*D +: D] = mem_read_data;
        e_rr[m_g] = 1;
        m_busy_mem = 0; m_busy_relay = 1;
      end else if (!m_rd && mem_write_ready) begin
        e_wv = 0;
        e_wr[m_g] = 1;
        m_busy_mem = 0; m_busy_relay = 1;
      end
    end else if (m_busy_relay) begin
      if (!(m_rd ? rv[m_g] : wv[m_g])) begin
        e_rr = '0; e_wr = '0;
        m_ptr = (m_g + 1) % N;
        m_busy_relay = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        mk = (m_ptr + i) % N;
        if (!m_busy_mem && (rv[mk] || wv[mk])) begin
          m_g = mk; m_rd = rv[mk]; m_busy_mem = 1;
          if (m_rd) begin
            e_rv = 1; e_ra = raddr[mk*A +: A];
          end else begin
            e_wv = 1; e_wa = waddr[mk*A +: A]; e_wd = wdata[mk*D +: D];
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      check("mem_read_valid", 32'(mem_read_valid), 32'(e_rv));
      check("mem_read_address", 32'(mem_read_address), 32'(e_ra));
      check("mem_write_valid", 32'(mem_write_valid), 32'(e_wv));
      check("mem_write_address", 32'(mem_write_address), 32'(e_wa));
      check("mem_write_data", 32'(mem_write_data), 32'(e_wd));
      check("read_ready", 32'(consumer_read_ready), 32'(e_rr));
      check("write_ready", 32'(consumer_write_ready), 32'(e_wr));
      check("read_data", 32'(consumer_read_data), 32'(e_rdata));
      check("one_mem_valid", 32'(mem_read_valid & mem_write_valid), 32'd0);
    end
  end

  // ---------------- LSU drivers ----------------
  task automatic lsu_read(input int k, input logic [A-1:0] a, input int hold, output logic [D-1:0] d);
    int n;
    @(negedge clk);
    rv[k] = 1'b1;
    raddr[k*A +: A] = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!consumer_read_ready[k] && n < 200);
    if (!consumer_read_ready[k]) begin
      vectors++; miscompares++;
      $display("FAIL read_timeout lsu %0d: ready never seen, required 1", k);
    end
    d = consumer_read_data[k*D +: D];
    repeat (hold) @(negedge clk);
    rv[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic lsu_write(input int k, input logic [A-1:0] a, input logic [D-1:0] dat, input int hold);
    int n;
    @(negedge clk);
    wv[k] = 1'b1;
    waddr[k*A +: A] = a;
    wdata[k*D +: D] = dat;
    n = 0;
    do begin @(negedge clk); n++; end while (!consumer_write_ready[k] && n < 200);
    if (!consumer_write_ready[k]) begin
      vectors++; miscompares++;
      $display("FAIL write_timeout lsu %0d: ready never seen, required 1", k);
    end
    repeat (hold) @(negedge clk);
    wv[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  logic [D-1:0] d0, d1, d2, d3;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[8'h10] = 8'hAB;

    #1 reset = 1'b1;
    #2;
    check("reset_outputs", {14'd0, mem_read_valid, mem_write_valid, consumer_read_ready,
                            consumer_write_ready, mem_read_address, mem_write_address}, 32'd0);
    check("reset_read_data", 32'(consumer_read_data), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single read, 3-cycle memory latency.
    lat = 3;
    rlog.delete();
    lsu_read(1, 8'h10, 0, d1);
    check("single_read_data", 32'(d1), 32'hAB);
    check("single_read_req_count", 32'(rlog.size()), 32'd1);
    check("single_read_addr", 32'(rlog[0]), 32'h10);

    // Pointer now sits at 2: LSU2 must beat LSU0.
    lat = 0;
    rlog.delete();
    fork
      lsu_read(0, 8'h30, 0, d0);
      lsu_read(2, 8'h32, 0, d2);
    join
    check("ptr2_order_count", 32'(rlog.size()), 32'd2);
    check("ptr2_first", 32'(rlog[0]), 32'h32);
    check("ptr2_second", 32'(rlog[1]), 32'h30);
    check("ptr2_data0", 32'(d0), 32'(8'h30 ^ 8'hC3));

    // Single write, ready held for 2 extra cycles.
    lat = 1;
    wlog_a.delete(); wlog_d.delete();
    lsu_write(2, 8'h20, 8'h5C, 2);
    check("single_write_count", 32'(wlog_a.size()), 32'd1);
    check("single_write_addr", 32'(wlog_a[0]), 32'h20);
    check("single_write_data", 32'(wlog_d[0]), 32'h5C);

    // Reset while a read is outstanding.
    lat = 10;
    @(negedge clk);
    rv[1] = 1'b1;
    raddr[1*A +: A] = 8'h33;
    repeat (3) @(negedge clk);
    check("pre_reset_read_valid", 32'(mem_read_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midop_reset_outputs", {14'd0, mem_read_valid, mem_write_valid, consumer_read_ready,
                                  consumer_write_ready, mem_read_address, mem_write_address}, 32'd0);
    rv[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", 32'(mem_read_valid | mem_write_valid), 32'd0);

    // Contention from pointer 0, then wrap-around fairness.
    lat = 0;
    rlog.delete();
    fork
      lsu_read(0, 8'h40, 0, d0);
      lsu_read(1, 8'h41, 0, d1);
      lsu_read(2, 8'h42, 0, d2);
      lsu_read(3, 8'h43, 0, d3);
    join
    check("cont_count", 32'(rlog.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("cont_order", 32'(rlog[i]), 32'(8'h40 + 8'(i)));
    check("cont_data3", 32'(d3), 32'(8'h43 ^ 8'hC3));
    rlog.delete();
    fork
      lsu_read(3, 8'h73, 0, d3);
      lsu_read(0, 8'h70, 0, d0);
    join
    check("wrap_count", 32'(rlog.size()), 32'd2);
    check("wrap_first", 32'(rlog[0]), 32'h70);
    check("wrap_second", 32'(rlog[1]), 32'h73);

    // Mixed read/write at the same time.
    lat = 2;
    rlog.delete(); wlog_a.delete(); wlog_d.delete();
    fork
      lsu_read(0, 8'h50, 1, d0);
      lsu_write(1, 8'h60, 8'h77, 0);
    join
    check("mixed_read_count", 32'(rlog.size()), 32'd1);
    check("mixed_write_count", 32'(wlog_a.size()), 32'd1);
    check("mixed_write_mem", 32'(mem[8'h60]), 32'h77);
    check("mixed_read_data", 32'(d0), 32'(8'h50 ^ 8'hC3));

    // LSU keeps valid 3 cycles after ready: no second request.
    lat = 0;
    rlog.delete();
    lsu_read(2, 8'h10, 3, d2);
    repeat (3) @(negedge clk);
    check("held_req_count", 32'(rlog.size()), 32'd1);
    check("held_read_data", 32'(d2), 32'hAB);
    check("held_retained_slice", 32'(consumer_read_data[2*D +: D]), 32'hAB);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
